// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: N-decade BCD up/down counter with load, wrap/saturate and terminal count
module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrapped,
    output logic                load_err
);
    localparam int W = 4 * DIGITS;
    logic [W-1:0] count_q, count_d, step_val, load_fix;
    logic [DIGITS:0] carry;
    logic [DIGITS-1:0] bad;
    logic wrapped_q, wrapped_d, load_err_q, load_err_d;
    // carry[i] means every digit below i sits at its limit (9 up, 0 down)
    assign carry[0] = 1'b1;
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [3:0] d, l;
        assign d = count_q[4*i +: 4];
        assign l = load_val[4*i +: 4];
        assign bad[i] = l > 4'd9;
        assign load_fix[4*i +: 4] = bad[i] ? 4'd0 : l;
        assign carry[i+1] = carry[i] & (up ? d == 4'd9 : d == 4'd0);
        assign step_val[4*i +: 4] = !carry[i] ? d :
                                    up ? (d == 4'd9 ? 4'd0 : d + 4'd1) :
                                         (d == 4'd0 ? 4'd9 : d - 4'd1);
    end
    always_comb begin
        count_d    = load ? load_fix : (en && !(carry[DIGITS] && !WRAP)) ? step_val : count_q;
        wrapped_d  = !load && en && carry[DIGITS] && WRAP;
        load_err_d = load && |bad;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            wrapped_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrapped_q  <= wrapped_d;
            load_err_q <= load_err_d;
        end
    end
    assign count    = count_q;
    assign tc       = en & carry[DIGITS];
    assign wrapped  = wrapped_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: scoreboard bench for a 4-digit wrapping and a 2-digit saturating counter
module tb_bcd_updown_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, up = 1'b1, load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] count_a;
    logic [7:0]  count_b;
    logic tc_a, wr_a, le_a, tc_b, wr_b, le_b;
    int checks = 0, errors = 0;

    typedef struct {
        bit          sel;
        logic [15:0] c;
        logic        t, w, e;
        string       nm;
    } exp_t;
    exp_t q[$];

    bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count_a), .tc(tc_a), .wrapped(wr_a), .load_err(le_a));
    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[7:0]),
        .count(count_b), .tc(tc_b), .wrapped(wr_b), .load_err(le_b));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic expect_now(input bit sel, input logic [15:0] c, input logic t, input logic w,
                              input logic e, input string nm);
        exp_t x;
        x.sel = sel; x.c = c; x.t = t; x.w = w; x.e = e; x.nm = nm;
        q.push_back(x);
    endtask

    // drive one cycle of inputs at a negedge and queue what the next edge must produce
    task automatic step(input bit sel, input logic e_i, input logic u_i, input logic l_i,
                        input logic [15:0] v, input logic [15:0] c, input logic t,
                        input logic w, input logic e, input string nm);
        en = e_i; up = u_i; load = l_i; load_val = v;
        expect_now(sel, c, t, w, e, nm);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            while (q.size() > 0) begin
                x = q.pop_front();
                if (!x.sel) begin
                    chk({x.nm, ".count"}, count_a, x.c);
                    chk({x.nm, ".tc"}, {15'd0, tc_a}, {15'd0, x.t});
                    chk({x.nm, ".wrapped"}, {15'd0, wr_a}, {15'd0, x.w});
                    chk({x.nm, ".load_err"}, {15'd0, le_a}, {15'd0, x.e});
                end else begin
                    chk({x.nm, ".count"}, {8'd0, count_b}, x.c);
                    chk({x.nm, ".tc"}, {15'd0, tc_b}, {15'd0, x.t});
                    chk({x.nm, ".wrapped"}, {15'd0, wr_b}, {15'd0, x.w});
                    chk({x.nm, ".load_err"}, {15'd0, le_b}, {15'd0, x.e});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    localparam bit A = 1'b0, B = 1'b1;

    initial begin : stim
        @(negedge clk);
        step(A, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, "rst_a");
        step(B, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, "rst_b");
        rst = 1'b1;
        step(A, 0, 1, 1, 16'h0427, 16'h0427, 0, 0, 0, "ld0427");
        step(A, 1, 1, 0, 16'h0000, 16'h0428, 0, 0, 0, "run0428");
        #2;
        expect_now(A, 16'h0000, 0, 0, 0, "async_rst");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(A, 1, 1, 0, 16'h0000, 16'h0001, 0, 0, 0, "post_rst");
        step(A, 0, 1, 1, 16'h0099, 16'h0099, 0, 0, 0, "ld0099");
        step(A, 1, 1, 0, 16'h0000, 16'h0100, 0, 0, 0, "carry0100");
        step(A, 1, 1, 0, 16'h0000, 16'h0101, 0, 0, 0, "carry0101");
        step(A, 0, 1, 1, 16'h9998, 16'h9998, 0, 0, 0, "ld9998");
        step(A, 1, 1, 0, 16'h0000, 16'h9999, 1, 0, 0, "up9999");
        step(A, 1, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, "upwrap");
        step(A, 1, 1, 0, 16'h0000, 16'h0001, 0, 0, 0, "postwrap");
        step(A, 0, 1, 1, 16'h1000, 16'h1000, 0, 0, 0, "ld1000");
        step(A, 1, 0, 0, 16'h0000, 16'h0999, 0, 0, 0, "borrow0999");
        step(A, 1, 0, 1, 16'h0000, 16'h0000, 1, 0, 0, "ld0000_tc");
        step(A, 1, 0, 0, 16'h0000, 16'h9999, 0, 1, 0, "dnwrap");
        step(A, 0, 1, 1, 16'h12A4, 16'h1204, 0, 0, 1, "badload");
        step(A, 0, 1, 0, 16'h0000, 16'h1204, 0, 0, 0, "badload_clr");
        step(A, 1, 1, 1, 16'h0500, 16'h0500, 0, 0, 0, "ld_wins");
        step(A, 0, 0, 0, 16'h0000, 16'h0500, 0, 0, 0, "hold_dn");
        step(A, 0, 1, 0, 16'h0000, 16'h0500, 0, 0, 0, "hold_up");
        step(B, 0, 1, 1, 16'h0098, 16'h0098, 0, 0, 0, "b_ld98");
        step(B, 1, 1, 0, 16'h0000, 16'h0099, 1, 0, 0, "b_up99");
        step(B, 1, 1, 0, 16'h0000, 16'h0099, 1, 0, 0, "b_sat1");
        step(B, 1, 1, 0, 16'h0000, 16'h0099, 1, 0, 0, "b_sat2");
        step(B, 1, 0, 0, 16'h0000, 16'h0098, 0, 0, 0, "b_dn98");
        step(B, 0, 0, 1, 16'h0001, 16'h0001, 0, 0, 0, "b_ld01");
        step(B, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, "b_dn00");
        step(B, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, "b_sat0");
        step(B, 0, 1, 1, 16'h00F3, 16'h0003, 0, 0, 1, "b_badload");
        en = 0; load = 0;
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
